mimc_hash_mp_stream: RTL and testbench
======================================

// Module: mimc_hash_mp_stream
// PURPOSE
// - Streaming MiMC engine: n-round MiMC block cipher with a valid/ready handshake, plus a Miyaguchi-Preneel (MP) hash
//   mode that absorbs a multi-block message and emits one digest.
// - Generalises the fixed x^7 / 91-round / single-shot cipher: exponent, round count and modulus are parameters.
// - Round constants come from an external ROM port.
// - Sits between a message-block source and a digest sink in the hash datapath; one internal modular multiplier is shared by all rounds.
// PARAMETERS
// - N_BITS     254            field element width
// - MODULUS    BN254 scalar r prime p, N_BITS wide; all inputs must be < p
// - ROUNDS     91             cipher rounds, >=1
// - EXPONENT   7              round power; legal values 3, 5, 7 (others: elaboration error)
// - MULT_METHOD "barrett"     selects the team multiplier implementation (start/done pulses, latency L>=1)
// PORTS
// - clk        in   1         clock, rising edge
// - rst        in   1         asynchronous reset, active-high
// - mode       in   1         0=cipher, 1=MP hash; sampled with the first block of a message
// - iv         in   N_BITS    MP initial chaining value h0; sampled with first block
// - key        in   N_BITS    cipher key (mode 0 only); sampled with block
// - in_data    in   N_BITS    plaintext (mode 0) / message block m_j (mode 1)
// - in_last    in   1         last block of message (ignored in mode 0: every block is last)
// - in_valid   in   1         block offered
// - in_ready   out  1         block accepted when in_valid&in_ready
// - rc_idx     out  clog2(ROUNDS) round-constant index, valid in ADD state
// - rc         in   N_BITS    c[rc_idx], combinational ROM return; the engine treats c[0] as 0 regardless of rc
// - out_data   out  N_BITS    ciphertext (mode 0) / digest (mode 1)
// - out_valid  out  1         result held until out_ready
// - out_ready  in   1         sink accepts when out_valid&out_ready
// BEHAVIOUR
// - Reset (async, any time, incl. mid-round): state=IDLE, in_ready=0 for that cycle then 1, out_valid=0, out_data=0, rc_idx=0.
//   The multiplier is also reset; an in-flight multiplier done is discarded.
// - Modular add/sub: sum formed N_BITS+1 wide; subtract p once if sum>=p. Result is always < p.
// - Round i (0..ROUNDS-1): t=(x+k+c_i) mod p; x=t^EXPONENT mod p. After the last round: E=(x+k) mod p.
// - Power chains, each mult issued start->wait done; next start the cycle after done:
//   - e=3: t2=t*t; t3=t2*t                  (M=2)
//   - e=5: t2, t4=t2*t2, t5=t4*t            (M=3)
//   - e=7: t2, t3=t2*t, t6=t3*t3, t7=t6*t   (M=4)
// - Cipher mode: k=key, x=in_data, out=E.
// - MP mode: k=h (h=iv on the first block), x=m_j; after each block h=(E+m_j+h) mod p.
//   After in_last, out=h and h reloads from iv on the next message's first block.
// - FSM: IDLE -(accept)-> ADD (1 cycle) -> POW (M*(L+1) cycles) -> ADD while round<ROUNDS-1, else FIN (1 cycle:
//   E, MP update) -> IDLE if MP and not last, else OUT.
// - OUT holds out_valid/out_data stable until out_ready. Handshake in OUT -> IDLE; in_ready rises the next cycle.
// - Latency per block (accept to out_valid, or to in_ready for a non-last MP block): ROUNDS*(1+M*(L+1))+1 cycles.
// - in_ready=1 only in IDLE; no new block is accepted while busy or while the output is pending (no overlap).
// - in_valid may drop without acceptance; no data captured. in_data/key/iv/mode/in_last are registered on acceptance only.
// - rc is read only in ADD; rc_idx equals the current round index there, and holds otherwise.
// - out_ready while out_valid=0 has no effect. out_valid&out_ready with simultaneous in_valid: the block is not accepted that cycle.
// TESTING (N_BITS=8, MODULUS=251, ROUNDS=1, EXPONENT=3, rc=0 unless noted)
// 1. mode0, key=0, in_data=5 -> out_data=125; then key=3, in_data=2 -> (5^3+3)=128.
// 2. mode1, iv=0, single block m=2 last -> digest 10 (E=8, h=8+2+0).
// 3. mode1, iv=0, blocks 2 then 1(last) -> digest 97 (E_10(1)=76+10=86; 86+1+10).
//    Next message (1 block, 2, last) -> digest 10 again (h reloaded from iv).
// 4. ROUNDS=2, EXPONENT=7, rc[1]=1, mode0, key=0, in_data=2: round0 t=2 -> 128; round1 t=(128+0+1) mod 251=129 -> 129^7 mod 251.
//    Check against golden model; rc_idx=1 during second ADD.
// 5. Backpressure: out_ready=0 for 20 cycles -> out_data stable, in_ready=0 throughout; release -> in_ready=1 the cycle after.
// 6. Assert rst in POW mid-message -> outputs zero immediately. Post-reset mode1 message 2(last) -> digest 10, no stale h.

Source files
------------

// File: rtl/mimc_hash_mp_stream.sv
// Streaming MiMC-n cipher with a Miyaguchi-Preneel hash mode. One shared modular
// multiplier (Barrett reduction, start/done handshake, latency 2) evaluates every round power.

module mimc_modmul #(
  parameter int                N_BITS  = 254,
  parameter logic [N_BITS-1:0] MODULUS = '1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic              done,
  output logic [N_BITS-1:0] y
);
  localparam int            W2 = 2*N_BITS + 2;
  localparam logic [W2-1:0] P  = W2'(MODULUS);
  // mu = floor(4^N / p); needs p >= 2^(N-1) so the quotient estimate is off by at most 2
  localparam logic [W2-1:0] MU = (W2'(1) << (2*N_BITS)) / P;

  logic [W2-1:0] prod, q, r0, r1, r2;
  logic          v1;

  always_comb begin
    q  = ((prod >> (N_BITS-1)) * MU) >> (N_BITS+1);
    r0 = prod - q * P;
    r1 = (r0 >= P) ? r0 - P : r0;
    r2 = (r1 >= P) ? r1 - P : r1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
      v1   <= 1'b0;
      done <= 1'b0;
      y    <= '0;
    end else begin
      v1   <= start;
      done <= v1;
      if (start) prod <= W2'(a) * W2'(b);
      if (v1)    y    <= r2[N_BITS-1:0];
    end
  end
endmodule

module mimc_hash_mp_stream #(
  parameter int                N_BITS      = 254,
  parameter logic [N_BITS-1:0] MODULUS     = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter int                ROUNDS      = 91,
  parameter int                EXPONENT    = 7,
  parameter string             MULT_METHOD = "barrett",
  localparam int               RW          = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [N_BITS-1:0] iv,
  input  logic [N_BITS-1:0] key,
  input  logic [N_BITS-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [RW-1:0]     rc_idx,
  input  logic [N_BITS-1:0] rc,
  output logic [N_BITS-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  if (!(EXPONENT == 3 || EXPONENT == 5 || EXPONENT == 7)) begin : g_bad_exp
    $error("mimc_hash_mp_stream: EXPONENT must be 3, 5 or 7");
  end
  if (ROUNDS < 1) begin : g_bad_rounds
    $error("mimc_hash_mp_stream: ROUNDS must be >= 1");
  end
  if (MULT_METHOD != "barrett") begin : g_bad_mult
    $error("mimc_hash_mp_stream: unsupported MULT_METHOD");
  end

  localparam int M = (EXPONENT == 3) ? 2 : (EXPONENT == 5) ? 3 : 4;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADD  = 3'd1;
  localparam logic [2:0] POW  = 3'd2;
  localparam logic [2:0] FIN  = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  function automatic logic [N_BITS-1:0] addm(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
    logic [N_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, MODULUS}) s = s - {1'b0, MODULUS};
    return s[N_BITS-1:0];
  endfunction

  logic [2:0]        state;
  logic [RW-1:0]     round;
  logic [1:0]        step;
  logic              issued, first, mode_r, last_r;
  logic [N_BITS-1:0] k, m, x, t, acc, h;

  logic              accept, cur_mode, sq, mul_start, mul_done, pow_last, last_round;
  logic [N_BITS-1:0] c_i, t_add, e_val, h_new, mul_a, mul_b, mul_y;

  assign rc_idx     = round;
  assign accept     = in_valid & in_ready;
  // mode latches with the first block; later blocks of an MP message follow it
  assign cur_mode   = first ? mode : mode_r;
  assign c_i        = (round == '0) ? '0 : rc;
  assign t_add      = addm(addm(x, k), c_i);
  assign e_val      = addm(x, k);
  assign h_new      = addm(addm(e_val, m), k);
  assign pow_last   = (step == 2'(M-1));
  assign last_round = (round == RW'(ROUNDS-1));

  // chain step 0 is t*t; later steps multiply the running product by itself or by t
  assign sq        = (step == 2'd0) || (EXPONENT == 5 && step == 2'd1) || (EXPONENT == 7 && step == 2'd2);
  assign mul_a     = (step == 2'd0) ? t : acc;
  assign mul_b     = sq ? mul_a : t;
  assign mul_start = (state == POW) && !issued;

  mimc_modmul #(.N_BITS(N_BITS), .MODULUS(MODULUS)) u_mul (
    .clk(clk), .rst(rst), .start(mul_start), .a(mul_a), .b(mul_b), .done(mul_done), .y(mul_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round     <= '0;
      step      <= '0;
      issued    <= 1'b0;
      first     <= 1'b1;
      mode_r    <= 1'b0;
      last_r    <= 1'b0;
      k         <= '0;
      m         <= '0;
      x         <= '0;
      t         <= '0;
      acc       <= '0;
      h         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= !accept;
          if (accept) begin
            mode_r <= cur_mode;
            first  <= !cur_mode || in_last;
            last_r <= !cur_mode || in_last;
            k      <= !cur_mode ? key : (first ? iv : h);
            if (cur_mode && first) h <= iv;
            m      <= in_data;
            x      <= in_data;
            round  <= '0;
            state  <= ADD;
          end
        end
        ADD: begin
          t      <= t_add;
          step   <= '0;
          issued <= 1'b0;
          state  <= POW;
        end
        POW: begin
          if (mul_start) issued <= 1'b1;
          if (mul_done) begin
            acc    <= mul_y;
            issued <= 1'b0;
            step   <= step + 2'd1;
            if (pow_last) begin
              x <= mul_y;
              if (last_round) state <= FIN;
              else begin
                round <= round + 1'b1;
                state <= ADD;
              end
            end
          end
        end
        FIN: begin
          if (mode_r) h <= h_new;
          if (mode_r && !last_r) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            out_data  <= mode_r ? h_new : e_val;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mimc_hash_mp_stream.sv
// Directed bench: p=251 instances (1 round x^3, and 2 rounds x^7 with a ROM) against a message-level model.
module tb_mimc_hash_mp_stream;
  localparam int P = 251;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       mode, in_last, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] iv, key, in_data, rc, out_data;
  logic [0:0] rc_idx;

  logic       in_valid1, in_ready1, out_valid1;
  logic [7:0] key1, in_data1, rc1, out_data1;
  logic [0:0] rc_idx1;

  mimc_hash_mp_stream #(.N_BITS(8), .MODULUS(8'd251), .ROUNDS(1), .EXPONENT(3), .MULT_METHOD("barrett")) dut (
    .clk(clk), .rst(rst), .mode(mode), .iv(iv), .key(key), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .rc_idx(rc_idx), .rc(rc), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mimc_hash_mp_stream #(.N_BITS(8), .MODULUS(8'd251), .ROUNDS(2), .EXPONENT(7), .MULT_METHOD("barrett")) dut1 (
    .clk(clk), .rst(rst), .mode(1'b0), .iv(8'd0), .key(key1), .in_data(in_data1), .in_last(1'b1),
    .in_valid(in_valid1), .in_ready(in_ready1), .rc_idx(rc_idx1), .rc(rc1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(1'b1)
  );

  // ROM: c[0] deliberately nonzero, the engine must ignore it
  always_comb rc1 = (rc_idx1 == 1'b1) ? 8'd1 : 8'd7;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // E_k(x) with round constant c1 for round 1 (c0 is always 0)
  function automatic int mimc_e(input int x0, input int k, input int rounds, input int e, input int c1);
    int x, t;
    longint r;
    x = x0;
    for (int i = 0; i < rounds; i++) begin
      t = (x + k + ((i == 1) ? c1 : 0)) % P;
      r = 1;
      for (int j = 0; j < e; j++) r = (r * t) % P;
      x = int'(r);
    end
    return (x + k) % P;
  endfunction

  int  exp_q[$];
  int  h_m;
  bit  first_m = 1'b1;
  bit  mode_m;

  function automatic void model_accept(input bit md, input int ivv, input int k, input int d, input bit last);
    int e;
    if (first_m) begin
      mode_m = md;
      h_m    = ivv;
    end
    if (!mode_m) begin
      exp_q.push_back(mimc_e(d, k, 1, 3, 0));
      first_m = 1'b1;
    end else begin
      e   = mimc_e(d, h_m, 1, 3, 0);
      h_m = (e + d + h_m) % P;
      if (last) exp_q.push_back(h_m);
      first_m = last;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) check("unexpected_output", out_valid, 1'b0);
      else check("stream_data", out_data, exp_q[0]);
      if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  task automatic send(input bit md, input int ivv, input int k, input int d, input bit last);
    int n;
    n = 0;
    mode = md; iv = 8'(ivv); key = 8'(k); in_data = 8'(d); in_last = last; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_accept(md, ivv, k, d, last);
        break;
      end
      n++;
      if (n > 200) begin
        check("accept_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_out(input int lit, input string nm);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 200) break;
    end
    check(nm, out_data, lit);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    mode = 1'b0; iv = '0; key = '0; in_data = '0; in_last = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; rc = '0; in_valid1 = 1'b0; key1 = '0; in_data1 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_rc_idx", rc_idx, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    check("model_e3", mimc_e(5, 0, 1, 3, 0), 125);
    check("model_e3_key", mimc_e(2, 3, 1, 3, 0), 128);
    check("model_e10", mimc_e(1, 10, 1, 3, 0), 86);
    check("model_r2e7", mimc_e(2, 0, 2, 7, 1), 55);

    send(0, 0, 0, 5, 1);  wait_out(125, "cipher_k0");
    send(0, 0, 3, 2, 1);  wait_out(128, "cipher_k3");
    send(1, 0, 0, 2, 1);  wait_out(10, "mp_single");
    send(1, 0, 0, 2, 0);
    send(1, 0, 0, 1, 1);  wait_out(97, "mp_two_block");
    send(1, 0, 0, 2, 1);  wait_out(10, "mp_iv_reload");

    // two rounds of x^7 with rc[1]=1
    key1 = 8'd0; in_data1 = 8'd2; in_valid1 = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (in_ready1) break;
      n++;
    end
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(negedge clk);
    check("r2_rc_idx_round0", rc_idx1, 0);
    n = 0;
    while (n < 100 && rc_idx1 != 1'b1) begin @(negedge clk); n++; end
    check("r2_rc_idx_round1", rc_idx1, 1);
    n = 0;
    while (n < 200 && !out_valid1) begin @(negedge clk); n++; end
    check("r2_e7_lit", out_data1, 55);
    check("r2_e7_model", out_data1, mimc_e(2, 0, 2, 7, 1));
    @(posedge clk);
    #1;

    // backpressure
    out_ready = 1'b0;
    send(0, 0, 0, 5, 1);
    @(negedge clk);
    check("busy_in_ready", in_ready, 0);
    n = 0;
    while (n < 200 && !out_valid) begin @(negedge clk); n++; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_data", out_data, 125);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    mode = 1'b0; key = 8'd3; in_data = 8'd2; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_accept(0, 0, 3, 2, 1);
    wait_out(128, "after_backpressure");

    // reset during POW of a non-last MP block
    send(1, 0, 0, 3, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_data", out_data, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_rc_idx", rc_idx, 0);
    first_m = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(1, 0, 0, 2, 1);  wait_out(10, "post_reset_mp");

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
